// File: rtl/wombat_pkt_stats.sv
// wombat_pkt_stats: snooping packet counters and per-window egress byte throughput
module wombat_pkt_stats #(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_CNT_WIDTH   = 32,
    parameter int C_TPUT_WINDOW = 156250000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      stats_en,
    input  logic                      s_in_tvalid,
    input  logic                      s_in_tready,
    input  logic                      s_in_tlast,
    input  logic                      s_out_tvalid,
    input  logic                      s_out_tready,
    input  logic                      s_out_tlast,
    input  logic [C_DATA_WIDTH/8-1:0] s_out_tkeep,
    input  logic                      pktin_reg_clear,
    input  logic                      pktout_reg_clear,
    output logic [C_CNT_WIDTH-1:0]    pktin_reg,
    output logic [C_CNT_WIDTH-1:0]    pktout_reg,
    output logic [C_CNT_WIDTH-1:0]    tput_reg,
    output logic                      tput_update
);
    localparam int KW = C_DATA_WIDTH / 8;
    localparam int BW = $clog2(KW + 1);
    localparam int WW = $clog2(C_TPUT_WINDOW);

    logic [C_CNT_WIDTH-1:0] pin_q, pin_d, pout_q, pout_d, tput_q, tput_d, acc_q, acc_d;
    logic [WW-1:0]          wcnt_q, wcnt_d;
    logic                   upd_q, upd_d;
    logic                   out_beat, in_add, out_add, term;
    logic [BW-1:0]          bytes;
    logic [C_CNT_WIDTH:0]   pin_inc, pout_inc, acc_sum;
    logic [C_CNT_WIDTH-1:0] pin_sat, pout_sat, acc_sat;

    // byte enables of the current egress beat, counted without assuming contiguity
    always_comb begin
        bytes = '0;
        for (int i = 0; i < KW; i++) bytes = bytes + BW'(s_out_tkeep[i]);
    end

    // event decode, saturating increments and window bookkeeping
    always_comb begin
        out_beat = s_out_tvalid & s_out_tready;
        in_add   = stats_en & s_in_tvalid & s_in_tready & s_in_tlast;
        out_add  = stats_en & out_beat & s_out_tlast;
        pin_inc  = {1'b0, pin_q} + 1'b1;
        pout_inc = {1'b0, pout_q} + 1'b1;
        acc_sum  = {1'b0, acc_q} + (C_CNT_WIDTH + 1)'(out_beat ? bytes : '0);
        pin_sat  = pin_inc[C_CNT_WIDTH] ? '1 : pin_inc[C_CNT_WIDTH-1:0];
        pout_sat = pout_inc[C_CNT_WIDTH] ? '1 : pout_inc[C_CNT_WIDTH-1:0];
        acc_sat  = acc_sum[C_CNT_WIDTH] ? '1 : acc_sum[C_CNT_WIDTH-1:0];
        term     = stats_en && (wcnt_q == WW'(C_TPUT_WINDOW - 1));
        pin_d    = pktin_reg_clear ? C_CNT_WIDTH'(in_add) : (in_add ? pin_sat : pin_q);
        pout_d   = pktout_reg_clear ? C_CNT_WIDTH'(out_add) : (out_add ? pout_sat : pout_q);
        wcnt_d   = (!stats_en || term) ? '0 : wcnt_q + 1'b1;
        acc_d    = (!stats_en || term) ? '0 : acc_sat;
        tput_d   = term ? acc_sat : tput_q;
        upd_d    = term;
    end

    // state registers; the closing window's total and its update pulse land together
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pin_q  <= '0;
            pout_q <= '0;
            tput_q <= '0;
            acc_q  <= '0;
            wcnt_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            pin_q  <= pin_d;
            pout_q <= pout_d;
            tput_q <= tput_d;
            acc_q  <= acc_d;
            wcnt_q <= wcnt_d;
            upd_q  <= upd_d;
        end
    end

    assign pktin_reg   = pin_q;
    assign pktout_reg  = pout_q;
    assign tput_reg    = tput_q;
    assign tput_update = upd_q;
endmodule

// File: tb/tb_wombat_pkt_stats.sv
// tb_wombat_pkt_stats: random and directed scoreboard bench against a cycle-level reference model
module tb_wombat_pkt_stats;
    localparam int DW  = 256;
    localparam int CW  = 9;
    localparam int W   = 16;
    localparam int KW  = DW / 8;
    localparam int MAX = (1 << CW) - 1;

    typedef struct {
        int pin;
        int pout;
        int tput;
        int upd;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn, en, iv, ir, il, ov, or_, ol, cin, cout;
    logic [KW-1:0] keep;
    logic [CW-1:0] pktin_reg, pktout_reg, tput_reg;
    logic          tput_update;

    exp_t q[$];
    int   tq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_pin, m_pout, m_tput, m_acc, m_w, m_upd;

    wombat_pkt_stats #(.C_DATA_WIDTH(DW), .C_CNT_WIDTH(CW), .C_TPUT_WINDOW(W)) dut (
        .clk(clk), .resetn(resetn), .stats_en(en),
        .s_in_tvalid(iv), .s_in_tready(ir), .s_in_tlast(il),
        .s_out_tvalid(ov), .s_out_tready(or_), .s_out_tlast(ol), .s_out_tkeep(keep),
        .pktin_reg_clear(cin), .pktout_reg_clear(cout),
        .pktin_reg(pktin_reg), .pktout_reg(pktout_reg), .tput_reg(tput_reg), .tput_update(tput_update)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int a);
        return a > MAX ? MAX : a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // reference: counters and window totals from the stated rules, one step per clock
    task automatic tick();
        exp_t e;
        int b;
        bit ei, eo;
        if (!resetn) begin
            m_pin = 0; m_pout = 0; m_tput = 0; m_acc = 0; m_w = 0; m_upd = 0;
        end else begin
            ei = en && iv && ir && il;
            eo = en && ov && or_ && ol;
            m_pin  = cin  ? int'(ei) : (ei ? sat(m_pin + 1)  : m_pin);
            m_pout = cout ? int'(eo) : (eo ? sat(m_pout + 1) : m_pout);
            m_upd = 0;
            if (en) begin
                b = (ov && or_) ? $countones(keep) : 0;
                if (m_w == W - 1) begin
                    m_tput = sat(m_acc + b);
                    m_acc = 0;
                    m_w = 0;
                    m_upd = 1;
                    tq.push_back(m_tput);
                end else begin
                    m_acc += b;
                    m_w++;
                end
            end else begin
                m_acc = 0;
                m_w = 0;
            end
        end
        e.pin = m_pin; e.pout = m_pout; e.tput = m_tput; e.upd = m_upd;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        iv = 0; ir = 0; il = 0; ov = 0; or_ = 0; ol = 0; keep = '0; cin = 0; cout = 0;
    endtask

    // monitor: per-cycle register check, plus window total whenever the update pulse shows
    always @(posedge clk) begin
        exp_t e;
        int t;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pktin_reg", int'(pktin_reg), e.pin);
            chk("pktout_reg", int'(pktout_reg), e.pout);
            chk("tput_reg", int'(tput_reg), e.tput);
            chk("tput_update", int'(tput_update), e.upd);
        end
        if (tput_update === 1'b1) begin
            if (tq.size() == 0) chk("tput_update_spurious", 1, 0);
            else begin
                t = tq.pop_front();
                chk("tput_window", int'(tput_reg), t);
            end
        end
    end

    initial begin
        resetn = 0; en = 0; idle();
        @(negedge clk);
        tick(); tick();
        resetn = 1; en = 1;
        for (int p = 0; p < 5; p++)
            for (int b = 0; b < 3; b++) begin
                iv = 1; ir = 1; il = (b == 2); tick();
            end
        idle(); tick();
        cin = 1; tick(); cin = 0; tick();
        for (int p = 0; p < 7; p++) begin
            iv = 1; ir = 1; il = 1; tick();
        end
        cin = 1; tick(); idle(); tick();
        for (int p = 0; p < MAX + 3; p++) begin
            ov = 1; or_ = 1; ol = 1; keep = KW'($urandom); tick();
        end
        idle(); tick();
        en = 0; tick(); en = 1;
        for (int c = 0; c < W; c++) begin
            idle();
            if (c < 10) begin ov = 1; or_ = 1; keep = '1; end
            tick();
        end
        idle();
        for (int c = 0; c < W; c++) tick();
        for (int c = 0; c < W; c++) begin
            ov = 1; or_ = 1; keep = '1; tick();
        end
        idle(); en = 0; tick(); en = 1;
        for (int c = 0; c < 2 * W; c++) begin
            idle();
            if (c == W - 1) begin ov = 1; or_ = 1; keep = KW'(32'h0000_00F1); end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            iv = 1; ir = 0; il = 1; ov = 1; or_ = 0; ol = 1; keep = '1; tick();
        end
        idle(); en = 0;
        for (int c = 0; c < W + 4; c++) begin
            ov = 1; or_ = 1; ol = 1; keep = '1; tick();
        end
        for (int n = 0; n < 3000; n++) begin
            resetn = ($urandom_range(0, 399) != 0);
            en = ($urandom_range(0, 24) != 0);
            iv = 1'($urandom); ir = 1'($urandom); il = 1'($urandom);
            ov = 1'($urandom); or_ = 1'($urandom); ol = 1'($urandom);
            case ($urandom_range(0, 3))
                0: keep = '0;
                1: keep = '1;
                default: keep = KW'($urandom);
            endcase
            cin = ($urandom_range(0, 15) == 0);
            cout = ($urandom_range(0, 15) == 0);
            tick();
        end
        resetn = 1; en = 0; idle();
        tick(); tick();
        @(posedge clk); #3;
        chk("scoreboard_drain", q.size(), 0);
        chk("tput_queue_drain", tq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
